// File: rtl/probe_capture.sv
// Probe capture: synchronises and debounces WIDTH probe pins, detects masked edge-qualified
// changes, pulses a trigger and logs {debounced value, timestamp} into a FWFT event FIFO.
module probe_capture #(
  parameter int WIDTH      = 8,
  parameter int DB_CYCLES  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              probe,
  input  logic [WIDTH-1:0]              mask,
  input  logic [1:0]                    mode,
  input  logic                          arm,
  input  logic                          clear_ovf,
  output logic [WIDTH-1:0]              data,
  output logic                          trigger,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [WIDTH-1:0]              evt_data,
  output logic [TS_WIDTH-1:0]           evt_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  logic [WIDTH-1:0]    sync1, sync2, db;
  logic [CW-1:0]       cnt [WIDTH];
  logic [WIDTH-1:0]    rise, fall, q;
  logic                hit, full, pop, push, drop;
  logic [TS_WIDTH-1:0] ts;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [WIDTH-1:0]    mem_data [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] mem_ts   [FIFO_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= probe;
      sync2 <= sync1;
    end
  end

  // A bit flips on its DB_CYCLES-th consecutive differing cycle; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    rise = db & ~data & mask;
    fall = ~db & data & mask;
    q    = '0;
    case (mode)
      2'b00:   q = rise | fall;
      2'b01:   q = rise;
      2'b10:   q = fall;
      default: q = '0;
    endcase
    hit = (|q) & arm;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data    <= '0;
      trigger <= 1'b0;
      ts      <= '0;
    end else begin
      data    <= db;
      trigger <= hit;
      ts      <= ts + TS_WIDTH'(1);
    end
  end

  // A pop frees the slot for a same-cycle push, so a full FIFO only drops when nobody drains it.
  assign full      = (fifo_count == DEPTH_C);
  assign evt_valid = (fifo_count != '0);
  assign pop       = evt_valid & evt_ready;
  assign push      = hit & (~full | pop);
  assign drop      = hit & full & ~pop;
  assign evt_data  = mem_data[rd_ptr];
  assign evt_ts    = mem_ts[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= db;
      mem_ts[wr_ptr]   <= ts;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + (AW + 1)'(1);
      else if (pop && !push) fifo_count <= fifo_count - (AW + 1)'(1);
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_probe_capture.sv
// Testbench for probe_capture: directed scenarios with literal expectations plus a randomized
// run, all compared every cycle against a queue-based behavioural model.
module tb_probe_capture;

  localparam int WIDTH = 8;
  localparam int DB    = 4;
  localparam int DEPTH = 16;
  localparam int TSW   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] probe, mask;
  logic [1:0]       mode;
  logic             arm, clear_ovf, evt_ready;
  logic [WIDTH-1:0] data, evt_data;
  logic             trigger, evt_valid, overflow;
  logic [TSW-1:0]   evt_ts;
  logic [4:0]       fifo_count;

  int errors = 0;
  int checks = 0;
  int edge_cnt;
  int trigs, total;

  always #5 clk = ~clk;

  probe_capture #(.WIDTH(WIDTH), .DB_CYCLES(DB), .FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clk(clk), .reset(reset), .probe(probe), .mask(mask), .mode(mode), .arm(arm),
    .clear_ovf(clear_ovf), .data(data), .trigger(trigger), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_data(evt_data), .evt_ts(evt_ts),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  // Behavioural model: sync is a 2-deep delay, debounce is a window over recent samples.
  typedef struct packed { logic [WIDTH-1:0] d; logic [TSW-1:0] t; } ent_t;
  ent_t             mq[$];
  ent_t             m_ent;
  logic [WIDTH-1:0] m_sh[$];
  logic [WIDTH-1:0] m_s1, m_s, m_db, m_dbn, m_data, m_q;
  logic [TSW-1:0]   m_ts;
  logic             m_trig, m_ovf, m_hit, m_all;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = '0; m_s = '0; m_db = '0; m_data = '0; m_ts = '0;
      m_trig = 1'b0; m_ovf = 1'b0;
      mq.delete();
      m_sh.delete();
    end else begin
      case (mode)
        2'b00:   m_q = (m_db ^ m_data) & mask;
        2'b01:   m_q = m_db & ~m_data & mask;
        2'b10:   m_q = ~m_db & m_data & mask;
        default: m_q = '0;
      endcase
      m_hit = (m_q != 0) && arm;
      if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
      if (m_hit && mq.size() == DEPTH) m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
      if (m_hit && mq.size() < DEPTH) begin
        m_ent.d = m_db;
        m_ent.t = m_ts;
        mq.push_back(m_ent);
      end
      m_trig = m_hit;
      m_data = m_db;
      m_sh.push_front(m_s);
      if (m_sh.size() > DB) void'(m_sh.pop_back());
      m_dbn = m_db;
      if (m_sh.size() == DB) begin
        for (int i = 0; i < WIDTH; i++) begin
          m_all = 1'b1;
          foreach (m_sh[j]) if (m_sh[j][i] == m_db[i]) m_all = 1'b0;
          if (m_all) m_dbn[i] = ~m_db[i];
        end
      end
      m_db = m_dbn;
      m_s  = m_s1;
      m_s1 = probe;
      m_ts = m_ts + 1'b1;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] p, input logic [7:0] mk, input logic [1:0] md, input logic a);
    probe = p;
    mask  = mk;
    mode  = md;
    arm   = a;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n, output int t);
    t = 0;
    repeat (n) begin
      tick(1);
      if (trigger === 1'b1) t++;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("model_data", data, m_data);
      checkOutput("model_trigger", trigger, m_trig);
      checkOutput("model_valid", evt_valid, mq.size() != 0);
      checkOutput("model_count", fifo_count, mq.size());
      checkOutput("model_overflow", overflow, m_ovf);
      if (mq.size() != 0) begin
        checkOutput("model_evt_data", evt_data, mq[0].d);
        checkOutput("model_evt_ts", evt_ts, mq[0].t);
      end
    end
  end

  initial begin
    reset = 1'b1;
    clear_ovf = 1'b0;
    evt_ready = 1'b0;
    applyStimulus(8'h00, 8'h00, 2'b00, 1'b0);
    tick(3);
    checkOutput("rst_data", data, 0);
    checkOutput("rst_trigger", trigger, 0);
    checkOutput("rst_valid", evt_valid, 0);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_overflow", overflow, 0);
    applyStimulus(8'h00, 8'hFF, 2'b00, 1'b1);
    reset = 1'b0;
    tick(3);

    probe = 8'h01;
    tick(3);
    probe = 8'h00;
    waitCycles(12, trigs);
    checkOutput("glitch_trig", trigs, 0);
    checkOutput("glitch_count", fifo_count, 0);
    checkOutput("glitch_data", data, 8'h00);

    probe = 8'h05;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      checkOutput("step_trig_latency", trigger, (k == 7));
    end
    checkOutput("step_data", data, 8'h05);
    checkOutput("step_count", fifo_count, 1);
    checkOutput("step_evt_data", evt_data, 8'h05);
    checkOutput("step_evt_ts", evt_ts, 16'(edge_cnt - 1));
    tick(1);
    checkOutput("step_trig_oneshot", trigger, 0);

    applyStimulus(8'h00, 8'hFF, 2'b11, 1'b1);
    waitCycles(10, trigs);
    checkOutput("off_trig", trigs, 0);
    checkOutput("off_data", data, 8'h00);
    applyStimulus(8'h11, 8'h0F, 2'b01, 1'b1);
    waitCycles(10, trigs);
    checkOutput("rise_trig", trigs, 1);
    checkOutput("rise_count", fifo_count, 2);
    applyStimulus(8'h10, 8'h0F, 2'b01, 1'b1);
    waitCycles(10, trigs);
    checkOutput("fall_masked_trig", trigs, 0);
    checkOutput("fall_masked_count", fifo_count, 2);
    checkOutput("fall_masked_data", data, 8'h10);

    evt_ready = 1'b1;
    tick(2);
    evt_ready = 1'b0;
    checkOutput("drain_count", fifo_count, 0);

    // Seventeen spaced changes against a stalled consumer
    applyStimulus(8'h10, 8'hFF, 2'b00, 1'b1);
    total = 0;
    for (int i = 0; i < 17; i++) begin
      probe = probe ^ 8'h01;
      waitCycles(8, trigs);
      total += trigs;
    end
    checkOutput("ovf_trig_total", total, 17);
    checkOutput("ovf_count", fifo_count, 16);
    checkOutput("ovf_flag", overflow, 1);
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    checkOutput("ovf_cleared", overflow, 0);

    probe = probe ^ 8'h01;
    tick(6);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    checkOutput("full_pop_trig", trigger, 1);
    checkOutput("full_pop_count", fifo_count, 16);
    checkOutput("full_pop_ovf", overflow, 0);
    checkOutput("full_pop_head", evt_data, 8'h10);
    tick(3);

    arm = 1'b0;
    total = 0;
    for (int i = 0; i < 3; i++) begin
      probe = probe ^ 8'h80;
      waitCycles(8, trigs);
      total += trigs;
    end
    checkOutput("disarm_trig", total, 0);
    checkOutput("disarm_count", fifo_count, 16);
    checkOutput("disarm_data", data, probe);

    evt_ready = 1'b1;
    tick(11);
    evt_ready = 1'b0;
    checkOutput("pre_reset_count", fifo_count, 5);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_data", data, 0);
    checkOutput("midrst_trigger", trigger, 0);
    checkOutput("midrst_valid", evt_valid, 0);
    checkOutput("midrst_count", fifo_count, 0);
    checkOutput("midrst_overflow", overflow, 0);
    applyStimulus(8'h05, 8'hFF, 2'b00, 1'b1);
    tick(2);
    reset = 1'b0;
    waitCycles(10, trigs);
    checkOutput("post_rst_trig", trigs, 1);
    checkOutput("post_rst_count", fifo_count, 1);
    checkOutput("post_rst_evt", evt_data, 8'h05);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) probe = probe ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) probe = 8'($urandom);
      if ($urandom_range(0, 99) == 0) mask = 8'($urandom);
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 49) == 0) arm = ($urandom_range(0, 9) != 0);
      evt_ready = ($urandom_range(0, 7) < (c / 750) + 1);
      clear_ovf = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
